// File: rtl/trace_cmd_dispatcher_if.sv
// trace_cmd_dispatcher_if: trace input and I/D cache dispatch handshakes
// master: trace source plus both cache sinks; slave: the dispatcher
interface trace_cmd_dispatcher_if #(parameter int N = 32);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_cmd;
  logic [N-1:0] in_addr;
  logic         ic_valid;
  logic         ic_ready;
  logic [3:0]   ic_cmd;
  logic [N-1:0] ic_addr;
  logic         dc_valid;
  logic         dc_ready;
  logic [3:0]   dc_cmd;
  logic [N-1:0] dc_addr;
  modport master (
    output in_valid, in_cmd, in_addr, ic_ready, dc_ready,
    input  in_ready, ic_valid, ic_cmd, ic_addr, dc_valid, dc_cmd, dc_addr
  );
  modport slave (
    input  in_valid, in_cmd, in_addr, ic_ready, dc_ready,
    output in_ready, ic_valid, ic_cmd, ic_addr, dc_valid, dc_cmd, dc_addr
  );
endinterface

// File: rtl/trace_cmd_dispatcher.sv
// trace_cmd_dispatcher: in-order trace FIFO routing commands to I-cache, D-cache or both
// clock/reset (async, active-low); bus: trace in + ic/dc dispatch handshakes;
// ic_count/dc_count: accepted commands per cache; drop_count: discarded codes;
// busy: FIFO non-empty or a command in flight
module trace_cmd_dispatcher #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int CW    = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  trace_cmd_dispatcher_if.slave   bus,
  output logic [CW-1:0]           ic_count,
  output logic [CW-1:0]           dc_count,
  output logic [CW-1:0]           drop_count,
  output logic                    busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   PONE = 1;
  localparam logic [CW-1:0] ONE  = 1;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t        state;
  logic [3:0]    cmd_q  [DEPTH];
  logic [N-1:0]  addr_q [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          ic_done, dc_done;
  logic [3:0]    head_cmd;
  logic [N-1:0]  head_addr;
  logic          full, empty, push, pop, to_ic, to_dc, drop, ic_fire, dc_fire;
  assign full      = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign empty     = wptr == rptr;
  assign push      = bus.in_valid && !full;
  assign pop       = state == IDLE && !empty;
  assign head_cmd  = cmd_q[rptr[AW-1:0]];
  assign head_addr = addr_q[rptr[AW-1:0]];
  assign to_ic     = head_cmd == 4'd2 || head_cmd == 4'd8 || head_cmd == 4'd9;
  assign to_dc     = head_cmd <= 4'd1 || head_cmd == 4'd3 || head_cmd == 4'd4 ||
                     head_cmd == 4'd8 || head_cmd == 4'd9;
  assign drop      = !to_ic && !to_dc;
  assign ic_fire   = bus.ic_valid && bus.ic_ready;
  assign dc_fire   = bus.dc_valid && bus.dc_ready;
  assign bus.in_ready = !full;
  assign busy      = !empty || state == ISSUE;
  always_ff @(posedge clock)
    if (push) begin
      cmd_q[wptr[AW-1:0]]  <= bus.in_cmd;
      addr_q[wptr[AW-1:0]] <= bus.in_addr;
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      state        <= IDLE;
      ic_done      <= 1'b0;
      dc_done      <= 1'b0;
      bus.ic_valid <= 1'b0;
      bus.ic_cmd   <= '0;
      bus.ic_addr  <= '0;
      bus.dc_valid <= 1'b0;
      bus.dc_cmd   <= '0;
      bus.dc_addr  <= '0;
      ic_count     <= '0;
      dc_count     <= '0;
      drop_count   <= '0;
    end else begin
      if (push) wptr <= wptr + PONE;
      if (pop) rptr <= rptr + PONE;
      if (state == IDLE) begin
        if (!empty && drop) drop_count <= drop_count + ONE;
        if (!empty && !drop) begin
          state   <= ISSUE;
          ic_done <= !to_ic;
          dc_done <= !to_dc;
          if (to_ic) begin
            bus.ic_valid <= 1'b1;
            bus.ic_cmd   <= head_cmd;
            bus.ic_addr  <= head_addr;
          end
          if (to_dc) begin
            bus.dc_valid <= 1'b1;
            bus.dc_cmd   <= head_cmd;
            bus.dc_addr  <= head_addr;
          end
          // clear command: counters restart here, its own acceptances count afterwards
          if (head_cmd == 4'd8) begin
            ic_count   <= '0;
            dc_count   <= '0;
            drop_count <= '0;
          end
        end
      end else begin
        if (ic_fire) begin
          bus.ic_valid <= 1'b0;
          ic_done      <= 1'b1;
          ic_count     <= ic_count + ONE;
        end
        if (dc_fire) begin
          bus.dc_valid <= 1'b0;
          dc_done      <= 1'b1;
          dc_count     <= dc_count + ONE;
        end
        // a side finishing on this edge counts as done for the return decision
        if ((ic_done || ic_fire) && (dc_done || dc_fire)) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_trace_cmd_dispatcher.sv
// tb_trace_cmd_dispatcher: directed checks of routing, ordering, FIFO full, drops/clear and reset
module tb_trace_cmd_dispatcher;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [31:0] ic_count, dc_count, drop_count;
  logic busy;
  int checks = 0;
  int errors = 0;
  trace_cmd_dispatcher_if #(.N(32)) bus ();
  trace_cmd_dispatcher #(.N(32), .DEPTH(4), .CW(32)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .ic_count(ic_count), .dc_count(dc_count), .drop_count(drop_count), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic push(input logic [3:0] c, input logic [31:0] a);
    bus.in_valid = 1'b1;
    bus.in_cmd   = c;
    bus.in_addr  = a;
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask
  initial begin
    int seq, conc, n;
    bus.in_valid = 1'b0;
    bus.in_cmd   = '0;
    bus.in_addr  = '0;
    bus.ic_ready = 1'b0;
    bus.dc_ready = 1'b0;
    tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_ic_valid", bus.ic_valid, 0);
    check("rst_dc_valid", bus.dc_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ic_addr", bus.ic_addr, 0);
    check("rst_counts", ic_count | dc_count | drop_count, 0);
    reset = 1'b1;
    bus.ic_ready = 1'b1;
    push(4'd2, 32'h3784_1A40);
    check("fetch_busy_push", busy, 1);
    check("fetch_ic_valid_push", bus.ic_valid, 0);
    tick();
    check("fetch_ic_valid", bus.ic_valid, 1);
    check("fetch_ic_addr", bus.ic_addr, 32'h3784_1A40);
    check("fetch_ic_cmd", bus.ic_cmd, 2);
    check("fetch_dc_valid", bus.dc_valid, 0);
    tick();
    check("fetch_ic_valid_done", bus.ic_valid, 0);
    check("fetch_ic_count", ic_count, 1);
    check("fetch_dc_count", dc_count, 0);
    check("fetch_busy_done", busy, 0);
    do_reset();
    bus.ic_ready = 1'b1;
    bus.dc_ready = 1'b0;
    push(4'd9, 32'h0);
    tick();
    check("bc_ic_valid", bus.ic_valid, 1);
    check("bc_dc_valid", bus.dc_valid, 1);
    tick();
    check("bc_ic_accepted", bus.ic_valid, 0);
    check("bc_ic_count", ic_count, 1);
    for (int i = 0; i < 4; i++) begin
      check("bc_dc_hold", bus.dc_valid, 1);
      check("bc_busy_hold", busy, 1);
      tick();
    end
    check("bc_dc_still", bus.dc_valid, 1);
    bus.dc_ready = 1'b1;
    tick();
    check("bc_dc_accepted", bus.dc_valid, 0);
    check("bc_dc_count", dc_count, 1);
    check("bc_ic_count_end", ic_count, 1);
    check("bc_busy_end", busy, 0);
    do_reset();
    bus.ic_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("full_in_ready_pre", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_cmd   = 4'd2;
      bus.in_addr  = 32'h100 + i;
      tick();
    end
    bus.in_addr = 32'h105;
    check("full_in_ready", bus.in_ready, 0);
    check("full_ic_valid", bus.ic_valid, 1);
    tick();
    check("full_sixth_held", bus.in_ready, 0);
    check("full_stall_addr", bus.ic_addr, 32'h100);
    bus.in_valid = 1'b0;
    bus.ic_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!bus.ic_valid && n < 10) begin
        tick();
        n++;
      end
      check("drain_valid", bus.ic_valid, 1);
      check("drain_addr", bus.ic_addr, 32'h100 + i);
      tick();
    end
    check("drain_ic_count", ic_count, 5);
    check("drain_busy", busy, 0);
    check("drain_in_ready", bus.in_ready, 1);
    do_reset();
    bus.ic_ready = 1'b1;
    bus.dc_ready = 1'b1;
    push(4'd5, 32'h1);
    push(4'd7, 32'h2);
    push(4'd15, 32'h3);
    push(4'd0, 32'h4);
    push(4'd8, 32'h5);
    tick();
    check("drop_count3", drop_count, 3);
    check("drop_dc_count1", dc_count, 1);
    tick();
    check("clr_drop_zero", drop_count, 0);
    check("clr_dc_zero", dc_count, 0);
    check("clr_both_valid", {30'd0, bus.ic_valid, bus.dc_valid}, 3);
    check("clr_ic_cmd", bus.ic_cmd, 8);
    tick();
    check("clr_ic_count", ic_count, 1);
    check("clr_dc_count", dc_count, 1);
    check("clr_drop_end", drop_count, 0);
    check("clr_busy", busy, 0);
    do_reset();
    bus.ic_ready = 1'b1;
    bus.dc_ready = 1'b1;
    seq = 0;
    conc = 0;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = i < 4;
      bus.in_cmd   = (i % 2 == 0) ? 4'd2 : (i == 1 ? 4'd0 : 4'd1);
      bus.in_addr  = 32'h200 + i;
      tick();
      if (bus.ic_valid && bus.dc_valid) conc++;
      if (bus.ic_valid || bus.dc_valid) seq = seq * 4 + (bus.ic_valid ? 1 : 0) + (bus.dc_valid ? 2 : 0);
    end
    bus.in_valid = 1'b0;
    check("order_seq", seq, 102);
    check("order_concurrent", conc, 0);
    check("order_ic_count", ic_count, 2);
    check("order_dc_count", dc_count, 2);
    bus.ic_ready = 1'b0;
    bus.dc_ready = 1'b0;
    push(4'd0, 32'h10);
    push(4'd2, 32'h11);
    push(4'd1, 32'h12);
    check("rmid_dc_valid_pre", bus.dc_valid, 1);
    check("rmid_busy_pre", busy, 1);
    reset = 1'b0;
    #1;
    check("rmid_dc_valid", bus.dc_valid, 0);
    check("rmid_busy", busy, 0);
    check("rmid_in_ready", bus.in_ready, 1);
    check("rmid_counts", ic_count | dc_count | drop_count, 0);
    #2;
    reset = 1'b1;
    bus.ic_ready = 1'b1;
    bus.dc_ready = 1'b1;
    conc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ic_valid || bus.dc_valid || busy) conc++;
    end
    check("rmid_no_dispatch", conc, 0);
    check("rmid_counts_end", ic_count | dc_count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
